// File: rtl/snoopy_collision_fsm.sv
// Game-state stage behind the Snoopy motion FSM: sprite/obstacle overlap, BCD score of
// cleared obstacles, and the IDLE -> PLAYING -> HIT (flash) -> GAME_OVER sequence.
module snoopy_collision_fsm #(
    parameter int unsigned SNOOPY_X      = 20,
    parameter int unsigned SNOOPY_W      = 16,
    parameter int unsigned SNOOPY_H      = 16,
    parameter int unsigned OBS_W         = 8,
    parameter int unsigned OBS_H         = 8,
    parameter int unsigned GROUND_HEIGHT = 100,
    parameter int unsigned FLASH_FRAMES  = 60,
    parameter int unsigned FLASH_PERIOD  = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        start,
    input  logic [6:0]  snoopy_y,
    input  logic [7:0]  obstacle_x,
    input  logic        obstacle_valid,
    output logic        playing,
    output logic        freeze,
    output logic        game_over,
    output logic        snoopy_visible,
    output logic [15:0] score,
    output logic        collision
);

    localparam int unsigned SUM_W   = 9;
    localparam int unsigned FLASH_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam int unsigned PER_W   = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
    localparam int unsigned SCORE_W = 16;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 16'h9999;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PLAYING   = 2'd1,
        S_HIT       = 2'd2,
        S_GAME_OVER = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [SCORE_W-1:0]   r_score, w_score_nxt;
    logic [FLASH_W-1:0]   r_flash_cnt, w_flash_cnt_nxt;
    logic [PER_W-1:0]     r_period_cnt, w_period_cnt_nxt;
    logic                 r_visible, w_visible_nxt;
    logic                 r_collision, r_passed_q;
    logic                 r_playing, r_freeze, r_game_over;

    logic [SUM_W-1:0]     w_y9, w_x9;
    logic                 w_vert, w_horiz, w_overlap, w_passed, w_score_evt;

    // Overlap and pass tests at 9-bit width so x + OBS_W cannot wrap.
    assign w_y9        = SUM_W'(snoopy_y);
    assign w_x9        = SUM_W'(obstacle_x);
    assign w_vert      = w_y9 > SUM_W'(GROUND_HEIGHT - OBS_H);
    assign w_horiz     = (w_x9 < SUM_W'(SNOOPY_X + SNOOPY_W)) &&
                         ((w_x9 + SUM_W'(OBS_W)) > SUM_W'(SNOOPY_X));
    assign w_overlap   = obstacle_valid && w_vert && w_horiz;
    assign w_passed    = obstacle_valid && ((w_x9 + SUM_W'(OBS_W)) <= SUM_W'(SNOOPY_X));
    assign w_score_evt = w_passed && !r_passed_q;

    function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
        logic [SCORE_W-1:0] r;
        logic               carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (r[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Next-state, score and flash sequencing.
    always_comb begin
        w_state_nxt      = r_state;
        w_score_nxt      = r_score;
        w_flash_cnt_nxt  = r_flash_cnt;
        w_period_cnt_nxt = r_period_cnt;
        w_visible_nxt    = r_visible;
        case (r_state)
            S_IDLE: begin
                w_score_nxt      = '0;
                w_flash_cnt_nxt  = '0;
                w_period_cnt_nxt = '0;
                w_visible_nxt    = 1'b1;
                if (start) w_state_nxt = S_PLAYING;
            end
            S_PLAYING: begin
                if (w_score_evt && (r_score != SCORE_MAX)) w_score_nxt = bcd_inc(r_score);
                if (frame_tick && r_collision) begin
                    w_state_nxt      = S_HIT;
                    w_flash_cnt_nxt  = '0;
                    w_period_cnt_nxt = '0;
                    w_visible_nxt    = 1'b1;
                end
            end
            S_HIT: begin
                if (frame_tick) begin
                    if (r_flash_cnt == FLASH_W'(FLASH_FRAMES - 1)) begin
                        w_state_nxt   = S_GAME_OVER;
                        w_visible_nxt = 1'b1;
                    end else begin
                        w_flash_cnt_nxt = r_flash_cnt + FLASH_W'(1);
                        if (r_period_cnt == PER_W'(FLASH_PERIOD - 1)) begin
                            w_period_cnt_nxt = '0;
                            w_visible_nxt    = !r_visible;
                        end else begin
                            w_period_cnt_nxt = r_period_cnt + PER_W'(1);
                        end
                    end
                end
            end
            S_GAME_OVER: begin
                w_visible_nxt = 1'b1;
                if (start) begin
                    w_state_nxt      = S_PLAYING;
                    w_score_nxt      = '0;
                    w_flash_cnt_nxt  = '0;
                    w_period_cnt_nxt = '0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_score      <= '0;
            r_flash_cnt  <= '0;
            r_period_cnt <= '0;
            r_visible    <= 1'b1;
            r_collision  <= 1'b0;
            r_passed_q   <= 1'b0;
            r_playing    <= 1'b0;
            r_freeze     <= 1'b1;
            r_game_over  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_score      <= w_score_nxt;
            r_flash_cnt  <= w_flash_cnt_nxt;
            r_period_cnt <= w_period_cnt_nxt;
            r_visible    <= w_visible_nxt;
            r_collision  <= w_overlap;
            r_passed_q   <= w_passed;
            r_playing    <= (w_state_nxt == S_PLAYING);
            r_freeze     <= (w_state_nxt != S_PLAYING);
            r_game_over  <= (w_state_nxt == S_GAME_OVER);
        end
    end

    assign playing        = r_playing;
    assign freeze         = r_freeze;
    assign game_over      = r_game_over;
    assign snoopy_visible = r_visible;
    assign score          = r_score;
    assign collision      = r_collision;

endmodule

// File: tb/tb_snoopy_collision_fsm.sv
// Randomized bench for snoopy_collision_fsm: a game-rule reference model feeds a
// scoreboard queue that a monitor drains one entry per clock.
module tb_snoopy_collision_fsm;

    localparam int SX = 20, SW = 16, OW = 8, OH = 8, GH = 100;
    localparam int FLASH_FRAMES = 60, FLASH_PERIOD = 8;

    logic        clock, reset, frame_tick, start, obstacle_valid;
    logic [6:0]  snoopy_y;
    logic [7:0]  obstacle_x;
    logic        playing, freeze, game_over, snoopy_visible, collision;
    logic [15:0] score;

    snoopy_collision_fsm dut (
        .clock(clock), .reset(reset), .frame_tick(frame_tick), .start(start),
        .snoopy_y(snoopy_y), .obstacle_x(obstacle_x), .obstacle_valid(obstacle_valid),
        .playing(playing), .freeze(freeze), .game_over(game_over),
        .snoopy_visible(snoopy_visible), .score(score), .collision(collision)
    );

    typedef struct {
        logic        playing, freeze, game_over, visible, collision;
        logic [15:0] score;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0, n_err = 0;

    // Reference model: 0 idle, 1 playing, 2 hit, 3 game over; score kept as a plain integer.
    int   m_phase, m_score, m_hit_ticks;
    bit   m_coll, m_passed_q;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] to_bcd(input int s);
        return {4'(s / 1000 % 10), 4'(s / 100 % 10), 4'(s / 10 % 10), 4'(s % 10)};
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.playing   = (m_phase == 1);
        e.freeze    = (m_phase != 1);
        e.game_over = (m_phase == 3);
        e.visible   = (m_phase == 2) ? (((m_hit_ticks / FLASH_PERIOD) % 2) == 0) : 1'b1;
        e.collision = m_coll;
        e.score     = to_bcd(m_score);
        return e;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_score = 0; m_hit_ticks = 0; m_coll = 0; m_passed_q = 0;
    endtask

    task automatic model_step(input bit tk, input bit st, input int y, input int x, input bit v);
        bit ov, ps, evt;
        ov  = v && (y > GH - OH) && (x < SX + SW) && (x + OW > SX);
        ps  = v && (x + OW <= SX);
        evt = ps && !m_passed_q;
        case (m_phase)
            0: begin
                m_score = 0; m_hit_ticks = 0;
                if (st) m_phase = 1;
            end
            1: begin
                if (evt && m_score < 9999) m_score++;
                if (tk && m_coll) begin m_phase = 2; m_hit_ticks = 0; end
            end
            2: if (tk) begin
                m_hit_ticks++;
                if (m_hit_ticks == FLASH_FRAMES) m_phase = 3;
            end
            default: if (st) begin m_phase = 1; m_score = 0; m_hit_ticks = 0; end
        endcase
        m_coll     = ov;
        m_passed_q = ps;
    endtask

    task automatic drive(input bit tk, input bit st, input int y, input int x, input bit v);
        @(negedge clock);
        frame_tick     = tk;
        start          = st;
        snoopy_y       = 7'(y);
        obstacle_x     = 8'(x);
        obstacle_valid = v;
        model_step(tk, st, y, x, v);
        q.push_back(model_out());
    endtask

    task automatic check_reset_values(input string name);
        n_vec++;
        if (playing !== 1'b0 || freeze !== 1'b1 || game_over !== 1'b0 ||
            snoopy_visible !== 1'b1 || score !== 16'h0000 || collision !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got play=%b frz=%b go=%b vis=%b score=%h coll=%b, want 0 1 0 1 0000 0",
                     name, playing, freeze, game_over, snoopy_visible, score, collision);
        end
    endtask

    // Asynchronous reset between clock edges; outputs checked before any edge arrives.
    task automatic reset_pulse(input string name);
        @(posedge clock);
        #2 reset = 1'b0;
        #1 check_reset_values(name);
        #1 reset = 1'b1;
        model_reset();
    endtask

    function automatic int pick_x();
        case ($urandom_range(11, 0))
            0: return 11;  1: return 12;  2: return 13;  3: return 14;
            4: return 34;  5: return 35;  6: return 36;  7: return 37;
            8: return 0;   9: return 255;
            default: return int'($urandom_range(255, 0));
        endcase
    endfunction

    function automatic int pick_y();
        case ($urandom_range(7, 0))
            0: return 92;  1: return 93;  2: return 100;  3: return 127;
            default: return int'($urandom_range(127, 0));
        endcase
    endfunction

    // Monitor: one expected vector per clock whenever stimulus has queued one.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                n_vec++;
                if (playing !== e.playing || freeze !== e.freeze || game_over !== e.game_over ||
                    snoopy_visible !== e.visible || score !== e.score || collision !== e.collision) begin
                    n_err++;
                    $display("FAIL scoreboard t=%0t: got play=%b frz=%b go=%b vis=%b score=%h coll=%b, want %b %b %b %b %h %b",
                             $time, playing, freeze, game_over, snoopy_visible, score, collision,
                             e.playing, e.freeze, e.game_over, e.visible, e.score, e.collision);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; frame_tick = 0; start = 0; snoopy_y = '0; obstacle_x = '0; obstacle_valid = 0;
        model_reset();
        repeat (3) @(posedge clock);
        #2 check_reset_values("power_on_reset");
        #1 reset = 1'b1;

        // Start, grounded Snoopy, obstacle sweeping into the sprite, then a tick -> HIT.
        drive(0, 1, 100, 40, 1);
        for (int x = 40; x >= 30; x--) drive(0, 0, 100, x, 1);
        drive(1, 0, 100, 30, 1);
        repeat (4) drive(0, 0, 100, 30, 1);

        // Fully random play, biased toward the overlap/pass boundaries.
        for (int i = 0; i < 4000; i++)
            drive($urandom_range(2, 0) == 0, $urandom_range(3, 0) == 0, pick_y(), pick_x(),
                  $urandom_range(3, 0) != 0);

        // Airborne pass: exactly one score event on the sweep, none on the wrap to 200.
        reset_pulse("reset_mid_game");
        drive(0, 1, 90, 40, 1);
        for (int x = 40; x >= 0; x--) drive($urandom_range(1, 0), 0, 90, x, 1);
        for (int x = 200; x >= 180; x--) drive($urandom_range(1, 0), 0, 90, x, 1);

        // Score pump with start held: runs through 0099 -> 0100 and saturates at 9999.
        for (int i = 0; i < 22000; i++)
            drive($urandom_range(1, 0), 1, 90,
                  (i % 2 == 0) ? int'($urandom_range(12, 0)) : int'($urandom_range(255, 13)), 1);
        @(posedge clock);
        #2;
        n_vec++;
        if (score !== 16'h9999) begin
            n_err++;
            $display("FAIL score_saturation: got %h, want 9999", score);
        end

        // Collide with start held high through HIT and GAME_OVER, restarting each time.
        for (int i = 0; i < 600; i++)
            drive($urandom_range(3, 0) != 0, 1, 100, 30, 1);

        reset_pulse("reset_end");
        repeat (2) @(posedge clock);
        #2;
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
